// File: rtl/light_step_if.sv
// Step-scheduler port bundle: raw buttons and auto controls in,
// one-hot step pulse and status flags out.
interface light_step_if;
  logic       btn_up;
  logic       btn_down;
  logic       auto_en;
  logic       auto_dir;
  logic [1:0] button;
  logic       busy;
  logic       overrun;

  modport master (
    output btn_up,
    output btn_down,
    output auto_en,
    output auto_dir,
    input  button,
    input  busy,
    input  overrun
  );

  modport slave (
    input  btn_up,
    input  btn_down,
    input  auto_en,
    input  auto_dir,
    output button,
    output busy,
    output overrun
  );
endinterface

// File: rtl/light_step_scheduler.sv
// Debounced up/down buttons and an auto-step timer arbitrated
// into spaced one-cycle step pulses for the light FSM.
module light_step_scheduler #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TICK_CYCLES     = 50,
  parameter int GAP_CYCLES      = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  light_step_if.slave bus
);

  localparam int DW =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TW = $clog2(TICK_CYCLES);
  localparam int GW =
    (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [DW-1:0] DB_LAST =
    DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] TICK_LAST =
    TW'(TICK_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST =
    GW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [1:0]    raw;
  logic [1:0]    sync1_q;
  logic [1:0]    sync2_q;
  logic [1:0]    deb_q;
  logic [DW-1:0] db_cnt_q [2];
  logic [1:0]    accept;
  logic [1:0]    rise;

  logic [TW-1:0] tick_q;
  logic          tick_wrap;

  logic pend_up_q;
  logic pend_dn_q;
  logic pend_auto_q;
  logic pend_up_d;
  logic pend_dn_d;
  logic pend_auto_d;
  logic any_pend;
  logic grant;
  logic clr_up;
  logic clr_dn;
  logic clr_auto;
  logic ovr_d;

  logic [1:0]    grant_btn;
  logic [GW-1:0] gap_q;
  logic [1:0]    button_q;
  logic          overrun_q;

  assign raw = {bus.btn_down, bus.btn_up};

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  // accept fires on the edge the mismatch has lasted DEBOUNCE_CYCLES
  always_comb begin
    accept = '0;
    rise   = '0;
    for (int i = 0; i < 2; i++) begin
      accept[i] = (sync2_q[i] != deb_q[i]) &&
                  (db_cnt_q[i] == DB_LAST);
      rise[i]   = accept[i] && sync2_q[i];
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      deb_q <= '0;
      for (int i = 0; i < 2; i++) begin
        db_cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if ((sync2_q[i] == deb_q[i]) || accept[i]) begin
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + DW'(1);
        end
        if (accept[i]) begin
          deb_q[i] <= sync2_q[i];
        end
      end
    end
  end

  assign tick_wrap = bus.auto_en && (tick_q == TICK_LAST);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      tick_q <= '0;
    end else if (!bus.auto_en || tick_wrap) begin
      tick_q <= '0;
    end else begin
      tick_q <= tick_q + TW'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // a set on the grant edge of the same source survives the clear
  always_comb begin
    state_d   = state_q;
    grant     = 1'b0;
    grant_btn = 2'b00;
    clr_up    = 1'b0;
    clr_dn    = 1'b0;
    clr_auto  = 1'b0;
    any_pend  = pend_up_q | pend_dn_q | pend_auto_q;

    unique case (state_q)
      IDLE: begin
        if (any_pend) begin
          grant   = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = HOLD;
      HOLD: begin
        if (gap_q == '0) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (grant) begin
      priority case (1'b1)
        pend_up_q: begin
          clr_up    = 1'b1;
          grant_btn = 2'b01;
        end
        pend_dn_q: begin
          clr_dn    = 1'b1;
          grant_btn = 2'b10;
        end
        default: begin
          clr_auto  = 1'b1;
          grant_btn = bus.auto_dir ? 2'b10 : 2'b01;
        end
      endcase
    end

    pend_up_d   = (pend_up_q & ~clr_up) | rise[0];
    pend_dn_d   = (pend_dn_q & ~clr_dn) | rise[1];
    pend_auto_d = bus.auto_en &
                  ((pend_auto_q & ~clr_auto) | tick_wrap);

    ovr_d = (rise[0] & pend_up_q & ~clr_up) |
            (rise[1] & pend_dn_q & ~clr_dn) |
            (tick_wrap & pend_auto_q & ~clr_auto);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      pend_up_q   <= 1'b0;
      pend_dn_q   <= 1'b0;
      pend_auto_q <= 1'b0;
      button_q    <= 2'b00;
      overrun_q   <= 1'b0;
      gap_q       <= '0;
    end else begin
      pend_up_q   <= pend_up_d;
      pend_dn_q   <= pend_dn_d;
      pend_auto_q <= pend_auto_d;
      button_q    <= grant_btn;
      overrun_q   <= ovr_d;
      if (state_q == ISSUE) begin
        gap_q <= GAP_LAST;
      end else if ((state_q == HOLD) && (gap_q != '0)) begin
        gap_q <= gap_q - GW'(1);
      end
    end
  end

  assign bus.button  = button_q;
  assign bus.busy    = (state_q != IDLE);
  assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_light_step_scheduler.sv
// Bench for light_step_scheduler: directed scenarios plus random
// stimulus against a time-based reference model.
module tb_light_step_scheduler;

  localparam int D = 4;
  localparam int T = 8;
  localparam int G = 2;

  logic i_clk = 1'b0;
  logic i_reset;

  light_step_if bus ();
  light_step_if bus2 ();

  light_step_scheduler #(
    .DEBOUNCE_CYCLES(D),
    .TICK_CYCLES    (T),
    .GAP_CYCLES     (G)
  ) dut (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .bus    (bus)
  );

  light_step_scheduler #(
    .DEBOUNCE_CYCLES(D),
    .TICK_CYCLES    (2),
    .GAP_CYCLES     (G)
  ) dut2 (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .bus    (bus2)
  );

  always #5 i_clk = ~i_clk;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  logic [1:0] m_rawq [$];
  logic [1:0] m_synq [$];
  logic [1:0] m_deb;
  bit m_pu, m_pd, m_pa;
  int m_run, m_edge, m_free_at, m_gedge;
  bit m_granted;
  logic [1:0] exp_button;
  logic exp_busy, exp_overrun;

  task automatic model_reset();
    m_rawq.delete();
    m_synq.delete();
    m_deb = '0;
    m_pu = 0; m_pd = 0; m_pa = 0;
    m_run = 0;
    m_free_at = 0;
    m_granted = 0;
    exp_button = 2'b00;
    exp_busy = 1'b0;
    exp_overrun = 1'b0;
  endtask

  task automatic model_step(input logic [1:0] raw,
                            input logic en, input logic dir);
    logic [1:0] syn;
    logic [1:0] rise;
    bit flip, set_a, gu, gd, ga;
    rise = '0; gu = 0; gd = 0; ga = 0; set_a = 0;
    m_edge++;
    syn = (m_rawq.size() >= 2) ? m_rawq[m_rawq.size()-2] : 2'b00;
    m_rawq.push_back(raw);
    if (m_rawq.size() > 2) void'(m_rawq.pop_front());
    m_synq.push_back(syn);
    if (m_synq.size() > D) void'(m_synq.pop_front());
    for (int b = 0; b < 2; b++) begin
      flip = (m_synq.size() == D);
      foreach (m_synq[j]) if (m_synq[j][b] == m_deb[b]) flip = 0;
      if (flip) begin
        m_deb[b] = ~m_deb[b];
        rise[b] = m_deb[b];
      end
    end
    if (en) begin
      m_run++;
      set_a = ((m_run % T) == 0);
    end else begin
      m_run = 0;
    end
    exp_button = 2'b00;
    if (m_edge >= m_free_at && (m_pu || m_pd || m_pa)) begin
      if (m_pu) begin gu = 1; exp_button = 2'b01; end
      else if (m_pd) begin gd = 1; exp_button = 2'b10; end
      else begin ga = 1; exp_button = dir ? 2'b10 : 2'b01; end
      m_gedge = m_edge;
      m_free_at = m_edge + G + 2;
      m_granted = 1;
    end
    exp_overrun = (rise[0] && m_pu && !gu) ||
                  (rise[1] && m_pd && !gd) ||
                  (set_a && m_pa && !ga);
    m_pu = (m_pu && !gu) || rise[0];
    m_pd = (m_pd && !gd) || rise[1];
    m_pa = en && ((m_pa && !ga) || set_a);
    exp_busy = m_granted && m_edge >= m_gedge &&
               m_edge <= m_gedge + G;
  endtask

  task automatic tick();
    logic [1:0] raw;
    logic en, dir;
    raw = {bus.btn_down, bus.btn_up};
    en  = bus.auto_en;
    dir = bus.auto_dir;
    @(posedge i_clk);
    if (i_reset) model_reset();
    else model_step(raw, en, dir);
    #1;
  endtask

  task automatic idle(input int n);
    bus.btn_up = 0; bus.btn_down = 0; bus.auto_en = 0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    bus.btn_up = 0; bus.btn_down = 0;
    bus.auto_en = 0; bus.auto_dir = 0;
    bus2.btn_up = 0; bus2.btn_down = 0;
    bus2.auto_en = 0; bus2.auto_dir = 0;
    model_reset();
    m_edge = 0;
    #1;
    n_tests++;
    if (bus.button !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_button: got %b want 00", bus.button);
    end
    n_tests++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy: got %b want 0", bus.busy);
    end
    n_tests++;
    if (bus.overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_overrun: got %b want 0", bus.overrun);
    end
    n_tests++;
    if (bus2.button !== 2'b00 || bus2.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_dut2: got %b/%b want 00/0",
               bus2.button, bus2.busy);
    end
    tick(); tick();
    i_reset = 1'b0;
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic test_single_press();
    int first, pulses, busy_n;
    first = -1; pulses = 0; busy_n = 0;
    bus.btn_up = 1'b1;
    for (int c = 1; c <= 24; c++) begin
      tick();
      if (c == 12) bus.btn_up = 1'b0;
      n_tests++;
      if (bus.button !== exp_button || bus.busy !== exp_busy ||
          bus.overrun !== exp_overrun) begin
        n_fail++;
        $display("FAIL single_press c%0d: got %b/%b/%b want %b/%b/%b",
                 c, bus.button, bus.busy, bus.overrun,
                 exp_button, exp_busy, exp_overrun);
      end
      if (bus.button != 2'b00) begin
        pulses++;
        if (first < 0) first = c;
      end
      if (bus.busy) busy_n++;
    end
    n_tests++;
    if (pulses !== 1) begin
      n_fail++;
      $display("FAIL single_press_count: got %0d want 1", pulses);
    end
    n_tests++;
    if (first !== 7) begin
      n_fail++;
      $display("FAIL single_press_latency: got %0d want 7", first);
    end
    n_tests++;
    if (busy_n !== G + 1) begin
      n_fail++;
      $display("FAIL single_press_busy: got %0d want %0d", busy_n, G + 1);
    end
  endtask

  task automatic test_glitch();
    int pulses;
    pulses = 0;
    bus.btn_down = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (c == 3) bus.btn_down = 1'b0;
      n_tests++;
      if (bus.button !== exp_button || bus.busy !== exp_busy) begin
        n_fail++;
        $display("FAIL glitch c%0d: got %b/%b want %b/%b",
                 c, bus.button, bus.busy, exp_button, exp_busy);
      end
      if (bus.button != 2'b00 || bus.busy) pulses++;
    end
    n_tests++;
    if (pulses !== 0) begin
      n_fail++;
      $display("FAIL glitch_activity: got %0d want 0", pulses);
    end
  endtask

  task automatic test_simultaneous();
    int c_up, c_dn;
    c_up = -1; c_dn = -1;
    bus.btn_up = 1'b1;
    bus.btn_down = 1'b1;
    for (int c = 1; c <= 24; c++) begin
      tick();
      if (c == 12) begin
        bus.btn_up = 1'b0;
        bus.btn_down = 1'b0;
      end
      n_tests++;
      if (bus.button !== exp_button || bus.busy !== exp_busy ||
          bus.overrun !== exp_overrun) begin
        n_fail++;
        $display("FAIL simultaneous c%0d: got %b/%b/%b want %b/%b/%b",
                 c, bus.button, bus.busy, bus.overrun,
                 exp_button, exp_busy, exp_overrun);
      end
      if (bus.button == 2'b01 && c_up < 0) c_up = c;
      if (bus.button == 2'b10 && c_dn < 0) c_dn = c;
    end
    n_tests++;
    if (c_up !== 7 || c_dn !== 11) begin
      n_fail++;
      $display("FAIL simultaneous_order: got up@%0d dn@%0d want 7 11",
               c_up, c_dn);
    end
  endtask

  task automatic test_auto();
    int n_up_a, n_dn_b, n_bad;
    n_up_a = 0; n_dn_b = 0; n_bad = 0;
    bus.auto_en = 1'b1;
    bus.auto_dir = 1'b0;
    for (int c = 1; c <= 120; c++) begin
      tick();
      if (c == 40) bus.auto_dir = 1'b1;
      if (c == 80) bus.auto_en = 1'b0;
      n_tests++;
      if (bus.button !== exp_button || bus.busy !== exp_busy ||
          bus.overrun !== exp_overrun) begin
        n_fail++;
        $display("FAIL auto c%0d: got %b/%b/%b want %b/%b/%b",
                 c, bus.button, bus.busy, bus.overrun,
                 exp_button, exp_busy, exp_overrun);
      end
      if (c <= 40 && bus.button == 2'b01) n_up_a++;
      else if (c > 40 && c <= 80 && bus.button == 2'b10) n_dn_b++;
      else if (c != 81 && bus.button != 2'b00) n_bad++;
    end
    n_tests++;
    if (n_up_a !== 4) begin
      n_fail++;
      $display("FAIL auto_up_count: got %0d want 4", n_up_a);
    end
    n_tests++;
    if (n_dn_b !== 5) begin
      n_fail++;
      $display("FAIL auto_dn_count: got %0d want 5", n_dn_b);
    end
    n_tests++;
    if (n_bad !== 0) begin
      n_fail++;
      $display("FAIL auto_stray: got %0d want 0", n_bad);
    end
  endtask

  task automatic test_tick2_overrun();
    int n_p, n_o, p1, p2, o1;
    n_p = 0; n_o = 0; p1 = -1; p2 = -1; o1 = -1;
    bus2.auto_dir = 1'b0;
    bus2.auto_en = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (c == 7) bus2.auto_en = 1'b0;
      if (bus2.button != 2'b00) begin
        n_p++;
        if (p1 < 0) p1 = c;
        else if (p2 < 0) p2 = c;
      end
      if (bus2.overrun) begin
        n_o++;
        if (o1 < 0) o1 = c;
      end
    end
    n_tests++;
    if (n_p !== 2 || p1 !== 3 || p2 !== 7) begin
      n_fail++;
      $display("FAIL tick2_pulses: got %0d at %0d,%0d want 2 at 3,7",
               n_p, p1, p2);
    end
    n_tests++;
    if (n_o !== 1 || o1 !== 6) begin
      n_fail++;
      $display("FAIL tick2_overrun: got %0d at %0d want 1 at 6", n_o, o1);
    end
  endtask

  task automatic test_reset_mid();
    int pulses;
    pulses = 0;
    bus.btn_up = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (c == 4) bus.btn_up = 1'b0;
    end
    n_tests++;
    if (bus.button !== 2'b01 || exp_button !== 2'b01) begin
      n_fail++;
      $display("FAIL reset_mid_issue: got %b model %b want 01",
               bus.button, exp_button);
    end
    #2;
    i_reset = 1'b1;
    model_reset();
    #1;
    n_tests++;
    if (bus.button !== 2'b00 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_kill: got %b/%b want 00/0",
               bus.button, bus.busy);
    end
    tick();
    i_reset = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (bus.button != 2'b00 || bus.busy) pulses++;
    end
    n_tests++;
    if (pulses !== 0) begin
      n_fail++;
      $display("FAIL reset_mid_after: got %0d active want 0", pulses);
    end
  endtask

  task automatic test_random();
    int hold_up, hold_dn, hold_en, last;
    hold_up = 0; hold_dn = 0; hold_en = 0; last = -100;
    for (int c = 1; c <= 1500; c++) begin
      if (hold_up == 0) begin
        bus.btn_up = 1'($urandom_range(0, 1));
        hold_up = $urandom_range(1, 14);
      end
      if (hold_dn == 0) begin
        bus.btn_down = 1'($urandom_range(0, 1));
        hold_dn = $urandom_range(1, 14);
      end
      if (hold_en == 0) begin
        bus.auto_en = 1'($urandom_range(0, 1));
        hold_en = $urandom_range(5, 60);
      end
      if ($urandom_range(0, 9) == 0) bus.auto_dir = ~bus.auto_dir;
      hold_up--; hold_dn--; hold_en--;
      tick();
      n_tests++;
      if (bus.button !== exp_button || bus.busy !== exp_busy ||
          bus.overrun !== exp_overrun) begin
        n_fail++;
        $display("FAIL random c%0d: got %b/%b/%b want %b/%b/%b",
                 c, bus.button, bus.busy, bus.overrun,
                 exp_button, exp_busy, exp_overrun);
      end
      if (bus.button != 2'b00) begin
        n_tests++;
        if (bus.button == 2'b11 || c - last < G + 2) begin
          n_fail++;
          $display("FAIL random_spacing c%0d: got %b gap %0d want >= %0d",
                   c, bus.button, c - last, G + 2);
        end
        last = c;
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_press();
    idle(10);
    test_glitch();
    idle(10);
    test_simultaneous();
    idle(10);
    test_auto();
    idle(10);
    test_tick2_overrun();
    idle(6);
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
